// File: rtl/ps2_kmouse.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kmouse
// Description : PS/2 mouse front-end. Initialises the mouse into stream mode
//               (command 0xF4), decodes 3-byte movement packets and serves
//               Kempston-mouse X/Y/button registers at ports #FBDF/#FFDF/#FADF.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_kmouse #(
    parameter int unsigned INIT_DELAY    = 14_000_000,
    parameter int unsigned INHIBIT       = 3_360,
    parameter int unsigned FRAME_TIMEOUT = 56_000,
    parameter int unsigned ACK_TIMEOUT   = 560_000
) (
    input  logic        clk28,
    input  logic        usrrst_n,
    input  logic [15:0] bus_a_i,
    input  logic        bus_rd_i,
    input  logic        bus_ioreq_i,
    input  logic        en_i,
    input  logic        ps2m_clk_i,
    input  logic        ps2m_dat_i,
    output logic        ps2m_clk_oe_o,
    output logic        ps2m_dat_oe_o,
    output logic [7:0]  d_out_o,
    output logic        d_out_active_o,
    output logic        present_o
);

    localparam int         TMR_W   = $clog2(INIT_DELAY + INHIBIT + 1);
    localparam int         ACK_W   = $clog2(ACK_TIMEOUT + 1);
    localparam int         FTO_W   = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [7:0] TX_BYTE = 8'hF4;
    localparam logic       TX_PAR  = ~^TX_BYTE;

    typedef enum logic [2:0] {
        ST_WAIT    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_TXBITS  = 3'd2,
        ST_ACKWAIT = 3'd3,
        ST_STREAM  = 3'd4
    } state_t;

    state_t            state_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [ACK_W-1:0]  ack_tmr_q;
    logic [3:0]        tx_cnt_q;
    logic              clk_oe_q, dat_oe_q, present_q, aa_seen_q;

    logic [1:0]        clk_sync_q, dat_sync_q;
    logic              clk_filt_q, fall_q;
    logic [2:0]        filt_cnt_q;

    logic [3:0]        rx_cnt_q;
    logic [7:0]        rx_sr_q, rx_byte_q;
    logic              rx_valid_q;
    logic [FTO_W-1:0]  rx_tmr_q;

    logic [1:0]        idx_q;
    logic [4:0]        hdr_q;      // {Yovf, Xovf, M, R, L}
    logic [7:0]        dx_q;
    logic [7:0]        x_q, y_q, pend_x_q, pend_y_q;
    logic [2:0]        btn_q, pend_btn_q;
    logic              pend_q;
    logic [7:0]        x_d, y_d;
    logic [2:0]        btn_d;

    logic [7:0]        d_out_q;
    logic              d_out_active_q;

    logic              w_dat, w_rx_en, w_tx_phase, w_sel, w_unused;

    assign w_dat      = dat_sync_q[1];
    assign w_rx_en    = en_i && (state_q == ST_ACKWAIT || state_q == ST_STREAM);
    assign w_tx_phase = (state_q == ST_INHIBIT) || (state_q == ST_TXBITS) ||
                        (state_q == ST_ACKWAIT);
    assign w_sel      = bus_ioreq_i & bus_rd_i & en_i & (bus_a_i[7:0] == 8'hDF);
    assign w_unused   = ^{bus_a_i[15:11], bus_a_i[9]};

    // Two-flop synchronisers for the raw PS/2 pins
    always_ff @(posedge clk28 or negedge usrrst_n) begin
        if (!usrrst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2m_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2m_dat_i};
        end
    end

    // Glitch filter: a level change is accepted after 8 stable cycles; emits a fall pulse
    always_ff @(posedge clk28 or negedge usrrst_n) begin
        if (!usrrst_n) begin
            clk_filt_q <= 1'b1;
            filt_cnt_q <= 3'd0;
            fall_q     <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (clk_sync_q[1] != clk_filt_q) begin
                if (filt_cnt_q == 3'd7) begin
                    clk_filt_q <= clk_sync_q[1];
                    filt_cnt_q <= 3'd0;
                    fall_q     <= ~clk_sync_q[1];
                end else begin
                    filt_cnt_q <= filt_cnt_q + 3'd1;
                end
            end else begin
                filt_cnt_q <= 3'd0;
            end
        end
    end

    // Device-to-host frame receiver with start/parity/stop checks and stall timeout
    always_ff @(posedge clk28 or negedge usrrst_n) begin
        if (!usrrst_n) begin
            rx_cnt_q   <= 4'd0;
            rx_sr_q    <= 8'h00;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_tmr_q   <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            if (!w_rx_en) begin
                rx_cnt_q <= 4'd0;
                rx_tmr_q <= '0;
            end else if (fall_q) begin
                rx_tmr_q <= '0;
                if (rx_cnt_q == 4'd0) begin
                    if (!w_dat) rx_cnt_q <= 4'd1;
                end else if (rx_cnt_q <= 4'd8) begin
                    rx_sr_q  <= {w_dat, rx_sr_q[7:1]};
                    rx_cnt_q <= rx_cnt_q + 4'd1;
                end else if (rx_cnt_q == 4'd9) begin
                    rx_cnt_q <= (^{rx_sr_q, w_dat}) ? 4'd10 : 4'd0;
                end else begin
                    if (w_dat) begin
                        rx_byte_q  <= rx_sr_q;
                        rx_valid_q <= 1'b1;
                    end
                    rx_cnt_q <= 4'd0;
                end
            end else if (rx_cnt_q != 4'd0) begin
                if (rx_tmr_q == FTO_W'(FRAME_TIMEOUT - 1)) begin
                    rx_cnt_q <= 4'd0;
                    rx_tmr_q <= '0;
                end else begin
                    rx_tmr_q <= rx_tmr_q + 1'b1;
                end
            end
        end
    end

    // Initialisation FSM including the host-to-device transmitter of 0xF4
    always_ff @(posedge clk28 or negedge usrrst_n) begin
        if (!usrrst_n) begin
            state_q   <= ST_WAIT;
            tmr_q     <= '0;
            ack_tmr_q <= '0;
            tx_cnt_q  <= 4'd0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            present_q <= 1'b0;
            aa_seen_q <= 1'b0;
        end else if (!en_i) begin
            state_q   <= ST_WAIT;
            tmr_q     <= '0;
            ack_tmr_q <= '0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            present_q <= 1'b0;
            aa_seen_q <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    present_q <= 1'b0;
                    aa_seen_q <= 1'b0;
                    if (tmr_q == TMR_W'(INIT_DELAY - 1)) begin
                        tmr_q     <= '0;
                        ack_tmr_q <= '0;
                        clk_oe_q  <= 1'b1;
                        state_q   <= ST_INHIBIT;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                ST_INHIBIT: begin
                    tmr_q <= tmr_q + 1'b1;
                    // Start bit goes out while the clock is still held, then the clock is released
                    if (tmr_q == TMR_W'(INHIBIT - 1)) dat_oe_q <= 1'b1;
                    if (tmr_q == TMR_W'(INHIBIT)) begin
                        clk_oe_q <= 1'b0;
                        tx_cnt_q <= 4'd0;
                        state_q  <= ST_TXBITS;
                    end
                end
                ST_TXBITS: begin
                    if (fall_q) begin
                        tx_cnt_q <= tx_cnt_q + 4'd1;
                        if (tx_cnt_q < 4'd8) begin
                            dat_oe_q <= ~TX_BYTE[tx_cnt_q[2:0]];
                        end else if (tx_cnt_q == 4'd8) begin
                            dat_oe_q <= ~TX_PAR;
                        end else if (tx_cnt_q == 4'd9) begin
                            dat_oe_q <= 1'b0;
                        end else begin
                            tmr_q   <= '0;
                            state_q <= w_dat ? ST_WAIT : ST_ACKWAIT;
                        end
                    end
                end
                ST_ACKWAIT: begin
                    if (rx_valid_q) begin
                        if (rx_byte_q == 8'hFA) begin
                            state_q   <= ST_STREAM;
                            present_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                            tmr_q   <= '0;
                        end
                    end
                end
                ST_STREAM: begin
                    if (rx_valid_q) begin
                        aa_seen_q <= (rx_byte_q == 8'hAA);
                        // 0xAA then 0x00 is a self-test report: the mouse was re-plugged
                        if (aa_seen_q && rx_byte_q == 8'h00) begin
                            state_q   <= ST_WAIT;
                            present_q <= 1'b0;
                            tmr_q     <= '0;
                        end
                    end
                end
                default: state_q <= ST_WAIT;
            endcase
            // The whole command exchange must complete within the acknowledge window
            if (w_tx_phase) begin
                if (ack_tmr_q == ACK_W'(ACK_TIMEOUT - 1)) begin
                    state_q   <= ST_WAIT;
                    tmr_q     <= '0;
                    clk_oe_q  <= 1'b0;
                    dat_oe_q  <= 1'b0;
                    present_q <= 1'b0;
                end else begin
                    ack_tmr_q <= ack_tmr_q + 1'b1;
                end
            end
        end
    end

    // New register values for a completed packet, accumulating onto any pending update
    always_comb begin
        x_d   = pend_q ? pend_x_q : x_q;
        y_d   = pend_q ? pend_y_q : y_q;
        if (!hdr_q[3]) x_d = x_d + dx_q;
        if (!hdr_q[4]) y_d = y_d + rx_byte_q;
        btn_d = {~hdr_q[2], ~hdr_q[0], ~hdr_q[1]};
    end

    // Packet assembler and X/Y/button registers, deferring updates during a read
    always_ff @(posedge clk28 or negedge usrrst_n) begin
        if (!usrrst_n) begin
            idx_q      <= 2'd0;
            hdr_q      <= 5'd0;
            dx_q       <= 8'h00;
            x_q        <= 8'h00;
            y_q        <= 8'h00;
            btn_q      <= 3'b111;
            pend_q     <= 1'b0;
            pend_x_q   <= 8'h00;
            pend_y_q   <= 8'h00;
            pend_btn_q <= 3'b111;
        end else begin
            if (pend_q && !d_out_active_q) begin
                x_q    <= pend_x_q;
                y_q    <= pend_y_q;
                btn_q  <= pend_btn_q;
                pend_q <= 1'b0;
            end
            if (state_q != ST_STREAM) begin
                idx_q <= 2'd0;
            end else if (rx_valid_q) begin
                case (idx_q)
                    2'd0: begin
                        if (rx_byte_q[3]) begin
                            hdr_q <= {rx_byte_q[7:6], rx_byte_q[2:0]};
                            idx_q <= 2'd1;
                        end
                    end
                    2'd1: begin
                        dx_q  <= rx_byte_q;
                        idx_q <= 2'd2;
                    end
                    default: begin
                        idx_q <= 2'd0;
                        if (d_out_active_q) begin
                            pend_q     <= 1'b1;
                            pend_x_q   <= x_d;
                            pend_y_q   <= y_d;
                            pend_btn_q <= btn_d;
                        end else begin
                            x_q    <= x_d;
                            y_q    <= y_d;
                            btn_q  <= btn_d;
                            pend_q <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    // Kempston port decode with registered read data
    always_ff @(posedge clk28 or negedge usrrst_n) begin
        if (!usrrst_n) begin
            d_out_q        <= 8'hFF;
            d_out_active_q <= 1'b0;
        end else if (w_sel) begin
            d_out_active_q <= 1'b1;
            if (!bus_a_i[8])      d_out_q <= {5'b11111, btn_q};
            else if (bus_a_i[10]) d_out_q <= y_q;
            else                  d_out_q <= x_q;
        end else begin
            d_out_active_q <= 1'b0;
            d_out_q        <= 8'hFF;
        end
    end

    assign ps2m_clk_oe_o  = clk_oe_q;
    assign ps2m_dat_oe_o  = dat_oe_q;
    assign present_o      = present_q;
    assign d_out_o        = d_out_q;
    assign d_out_active_o = d_out_active_q;

endmodule
`default_nettype wire

// File: doc/ps2_kmouse.md
# ps2_kmouse

PS/2 mouse front-end feeding the CPU-visible port layer with Kempston-mouse data. It sits upstream of the I/O read multiplexer in the memory controller, alongside the ports, ULA+ and DivMMC `d_out`/`d_out_active` sources. It drives a second PS/2 connector, initialises the mouse into stream mode, and decodes 3-byte movement packets. From these it maintains the X, Y and button registers read at ports #FBDF, #FFDF and #FADF.

## Interface
Parameters:
- INIT_DELAY, 14_000_000: cycles waited after reset/retry before sending the enable command (500 ms).
- INHIBIT, 3_360: cycles the host holds the PS/2 clock low before transmitting (120 µs).
- FRAME_TIMEOUT, 56_000: cycles without a device clock edge mid-frame before the bit counter is abandoned (2 ms).
- ACK_TIMEOUT, 560_000: cycles allowed from the start of transmission to reception of 0xFA (20 ms).

Ports:
- clk28  in  1  system clock, 28 MHz.
- usrrst_n  in  1  reset, asynchronous, active-low.
- bus  in  cpu_bus  registered CPU bus snapshot; uses a, rd, ioreq.
- en  in  1  block enable from the magic configuration.
- ps2m_clk_in  in  1  raw PS/2 clock pin.
- ps2m_dat_in  in  1  raw PS/2 data pin.
- ps2m_clk_oe  out  1  1 = pull the clock line low (open drain).
- ps2m_dat_oe  out  1  1 = pull the data line low (open drain).
- d_out  out  8  read data.
- d_out_active  out  1  the block owns the current I/O read.
- present  out  1  the mouse has acknowledged 0xF4 and is streaming.

## Operation
- **Input conditioning.** Clock and data each pass through a 2-flop synchroniser. A falling clock edge is accepted only after the synchronised level has been stable low for 8 cycles, following a stable-high state.
- **Receiver.**
  - 11-bit frame: start=0, 8 data bits LSB first, odd parity, stop=1.
  - A bad start, parity or stop bit discards the byte and clears the bit counter.
  - If FRAME_TIMEOUT elapses with the bit counter ≠ 0, the bit counter clears.
- **Transmitter, sending 0xF4.**
  - Assert clk_oe for INHIBIT cycles.
  - Assert dat_oe (start bit), then release clk_oe.
  - On each device falling edge, present the next of 8 data bits (LSB first) on dat_oe (dat_oe = ~bit), then parity, then release for stop.
  - On the next falling edge, sample the device ACK (data low). A missing ACK means retry.
- **Initialisation FSM.**
  - WAIT: count INIT_DELAY → TX.
  - TX: transmit → ACKWAIT.
  - ACKWAIT: received 0xFA → STREAM with present=1. Any other byte or ACK_TIMEOUT → WAIT.
  - STREAM: the packet assembler runs. Receiving 0xAA followed by 0x00 (hot-plug) → WAIT with present=0.
- **Packet assembler, STREAM only.**
  - Byte 0 must have bit3=1; otherwise the byte is dropped and the assembler stays at index 0.
  - Byte 0 fields: b0=L, b1=R, b2=M, b4=Xsign, b5=Ysign, b6=Xovf, b7=Yovf.
  - Bytes 1 and 2 are the X and Y deltas.
- **Register update.** On the 3rd byte:
  - x ← x + byte1 mod 256, skipped if Xovf.
  - y ← y + byte2 mod 256, skipped if Yovf. Up is positive, matching Kempston.
  - btn ← {~M, ~L, ~R}.
  - All three registers update in the same cycle.
- **Port decode.** Requires bus.ioreq & bus.rd & en & a[7:0]=0xDF:
  - a[8]=0 → buttons, d_out = {5'b11111, btn}.
  - a[8]=1, a[10]=0 → X.
  - a[8]=1, a[10]=1 → Y.
- **Read consistency.** If a packet completes while d_out_active=1, the update is held pending and applied the cycle after bus.ioreq falls.
- **Disable.** en=0 forces the FSM to WAIT, releases both oe outputs, and holds present=0 and d_out_active=0. The registers keep their values.

## Timing
- **Reset values:** ps2m_clk_oe=0, ps2m_dat_oe=0, present=0, d_out_active=0, d_out=0xFF, x=0, y=0, btn=3'b111. FSM in WAIT, byte index 0.
- **Edge recognition latency:** 10 cycles from the pin edge (2 sync + 8 filter).
- **I/O read:** d_out and d_out_active are registered and valid 1 cycle after the qualifying bus snapshot. They stay valid while ioreq & rd hold and drop 1 cycle after either deasserts.
- **Packet update:** registers change 1 cycle after the stop bit of byte 2 is accepted (or per the pending rule).
- **Transmit data changes** occur within 10 cycles after the accepted device falling edge; the device samples on its rising edge.
- **Mid-operation reset:** async reset returns all state to reset values immediately; the oe outputs deassert combinationally with the reset.

## Test plan
- **Init handshake.** Reset, INIT_DELAY shortened to 100, INHIBIT to 50. Device model clocks the frame in → bits captured 0,0,0,1,0,1,1,1,1,0 (start, 0xF4 LSB first, parity=0), then release; host sees the device ACK. Device sends 0xFA → present=1.
- **ACK timeout.** Device silent after TX, ACK_TIMEOUT=1000 → FSM returns to WAIT and a second 0xF4 transmission starts after INIT_DELAY; present stays 0.
- **Packet.** Stream 0x09, 0x05, 0xFD → x=0x05, y=0xFD. Read #FADF → 0xFD (left pressed); read #FBDF → 0x05; read #FFDF → 0xFD.
- **Sync and error handling.**
  - Byte 0x00 (bit3=0) followed by a valid packet 0x08, 0x01, 0x01 → x=1, y=1.
  - A frame with bad parity is discarded with no register change.
  - Overflow packet 0x48, 0x80, 0x02 → x unchanged, y+=2.
- **Read consistency and wrap.** With x=0xFF, hold a read of #FBDF while the packet 0x08, 0x02, 0x00 completes → d_out stays 0xFF for the whole read; the next read returns 0x01.
- **Disable.** en=0 during STREAM → oe=0, present=0, no d_out_active on a #FADF read. Re-enable → a fresh init sequence runs.
